// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution-unit tile sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadK,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Bit positions inside each column's 8-bit control byte.
  localparam int unsigned ColLoadN    = 0;
  localparam int unsigned ColAccEn    = 1;
  localparam int unsigned ColClr      = 2;
  localparam int unsigned ColShiftOut = 3;
  localparam int unsigned ColBits     = 8;

  function automatic int unsigned common_width(input int unsigned dep, input int unsigned al);
    return 3 * dep + 2 * al;
  endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Step/tile counters and kernel/neuron buffer address registers for the sequencer.
module conv_seq_addr_gen import conv_seq_pkg::*; #(
  parameter int unsigned depth = 2,
  parameter int unsigned Al    = 7,
  parameter int unsigned Ab    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  state_e        state,
  input  logic          accept,
  input  logic          advance,
  input  logic [Al-1:0] kernel_step,
  input  logic [Al-1:0] neuron_step,
  input  logic [Al-1:0] mac_cycles,
  input  logic [Al-1:0] num_tiles,
  input  logic [Ab-1:0] k_base,
  input  logic [Ab-1:0] cfg_k_base,
  input  logic [Ab-1:0] cfg_n_base,
  output logic [Al-1:0] step_next,
  output logic          step_last,
  output logic          tile_last,
  output logic [Ab-1:0] k_addr,
  output logic [Ab-1:0] n_addr
);

  localparam int unsigned D = 1 << depth;

  logic [Al-1:0] step_q, step_d, tile_q, tile_d;
  logic [Ab-1:0] k_addr_q, k_addr_d, n_addr_q, n_addr_d, n_tile_q, n_tile_d;

  assign step_last = (state == StRun) ? (step_q == mac_cycles - Al'(1)) : (step_q == Al'(D - 1));
  assign tile_last = (tile_q == num_tiles - Al'(1));

  always_comb begin
    step_d   = step_q;
    tile_d   = tile_q;
    k_addr_d = k_addr_q;
    n_addr_d = n_addr_q;
    n_tile_d = n_tile_q;
    if (state == StIdle) begin
      if (accept) begin
        step_d   = '0;
        tile_d   = '0;
        k_addr_d = cfg_k_base;
        n_tile_d = cfg_n_base;
      end
    end else if (advance) begin
      case (state)
        StLoadK: begin
          if (step_last) begin
            step_d   = '0;
            n_addr_d = n_tile_q;
          end else begin
            step_d   = step_q + Al'(1);
            k_addr_d = k_addr_q + Ab'(kernel_step);
          end
        end
        StRun: begin
          if (step_last) begin
            step_d = '0;
          end else begin
            step_d   = step_q + Al'(1);
            n_addr_d = n_addr_q + Ab'(1);
          end
        end
        StDrain: begin
          if (step_last) begin
            step_d = '0;
            if (!tile_last) begin
              tile_d   = tile_q + Al'(1);
              k_addr_d = k_base;
              n_tile_d = n_tile_q + Ab'(neuron_step);
            end
          end else begin
            step_d = step_q + Al'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      tile_q   <= '0;
      k_addr_q <= '0;
      n_addr_q <= '0;
      n_tile_q <= '0;
    end else begin
      step_q   <= step_d;
      tile_q   <= tile_d;
      k_addr_q <= k_addr_d;
      n_addr_q <= n_addr_d;
      n_tile_q <= n_tile_d;
    end
  end

  assign step_next = step_d;
  assign k_addr    = k_addr_q;
  assign n_addr    = n_addr_q;

endmodule

// File: rtl/conv_unit_sequencer.sv
// Tile-level controller for the DxD PE mesh: kernel load, MAC run and psum drain per tile.
module conv_unit_sequencer import conv_seq_pkg::*; #(
  parameter  int unsigned depth = 2,
  parameter  int unsigned Al    = 7,
  parameter  int unsigned Ab    = 11,
  localparam int unsigned D     = 1 << depth,
  localparam int unsigned Cw    = common_width(depth, Al)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             hold,
  input  logic [depth-1:0] cfgTr,
  input  logic [depth-1:0] cfgTc,
  input  logic [Al-1:0]    cfgKernelStep,
  input  logic [Al-1:0]    cfgNeuronStep,
  input  logic [depth-1:0] cfgConvDivIni,
  input  logic [Al-1:0]    cfgMacCycles,
  input  logic [Al-1:0]    cfgNumTiles,
  input  logic [Ab-1:0]    cfgKBase,
  input  logic [Ab-1:0]    cfgNBase,
  output logic             busy,
  output logic             done,
  output logic             psumValid,
  output logic [Ab-1:0]    kBuffAddr,
  output logic [Ab-1:0]    nBuffAddr,
  output logic [D-1:0]     rowControl,
  output logic [8*D-1:0]   columnControl,
  output logic [Cw-1:0]    commonControl
);

  state_e state_q, state_d;
  logic active, accept, advance, frozen, step_last, tile_last;
  logic [Al-1:0] step_d;

  logic [depth-1:0] tr_q, tc_q, div_q;
  logic [Al-1:0]    kstep_q, nstep_q, mac_q, tiles_q;
  logic [Ab-1:0]    kbase_q;

  logic             busy_d, done_d, psum_d, busy_q, done_q, psum_q;
  logic [D-1:0]     row_d, row_q;
  logic [8*D-1:0]   col_d, col_q;

  assign active  = (state_q == StLoadK) || (state_q == StRun) || (state_q == StDrain);
  assign accept  = (state_q == StIdle) && start;
  assign advance = active && !hold;
  assign frozen  = active && hold;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoadK;
      StLoadK: if (advance && step_last) state_d = StRun;
      StRun:   if (advance && step_last) state_d = StDrain;
      StDrain: if (advance && step_last) state_d = tile_last ? StDone : StLoadK;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed for the position being entered, so they register in step with it.
  always_comb begin
    row_d  = '0;
    col_d  = '0;
    psum_d = 1'b0;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    if (!frozen) begin
      case (state_d)
        StLoadK: begin
          row_d[step_d[depth-1:0]] = 1'b1;
          if (step_d == '0) begin
            for (int c = 0; c < D; c++) col_d[c*ColBits + ColClr] = 1'b1;
          end
        end
        StRun: begin
          for (int c = 0; c < D; c++) begin
            col_d[c*ColBits + ColLoadN] = 1'b1;
            col_d[c*ColBits + ColAccEn] = 1'b1;
          end
        end
        StDrain: begin
          psum_d = 1'b1;
          for (int c = 0; c < D; c++) col_d[c*ColBits + ColShiftOut] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_q  <= '0;
      col_q  <= '0;
      psum_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      psum_q <= psum_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tr_q    <= '0;
      tc_q    <= '0;
      div_q   <= '0;
      kstep_q <= '0;
      nstep_q <= '0;
      mac_q   <= '0;
      tiles_q <= '0;
      kbase_q <= '0;
    end else if (accept) begin
      tr_q    <= cfgTr;
      tc_q    <= cfgTc;
      div_q   <= cfgConvDivIni;
      kstep_q <= cfgKernelStep;
      nstep_q <= cfgNeuronStep;
      mac_q   <= (cfgMacCycles == '0) ? Al'(1) : cfgMacCycles;
      tiles_q <= (cfgNumTiles == '0) ? Al'(1) : cfgNumTiles;
      kbase_q <= cfgKBase;
    end
  end

  conv_seq_addr_gen #(
    .depth (depth),
    .Al    (Al),
    .Ab    (Ab)
  ) u_addr_gen (
    .clk         (CLK),
    .rst_n       (RSTn),
    .state       (state_q),
    .accept      (accept),
    .advance     (advance),
    .kernel_step (kstep_q),
    .neuron_step (nstep_q),
    .mac_cycles  (mac_q),
    .num_tiles   (tiles_q),
    .k_base      (kbase_q),
    .cfg_k_base  (cfgKBase),
    .cfg_n_base  (cfgNBase),
    .step_next   (step_d),
    .step_last   (step_last),
    .tile_last   (tile_last),
    .k_addr      (kBuffAddr),
    .n_addr      (nBuffAddr)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign psumValid     = psum_q;
  assign rowControl    = row_q;
  assign columnControl = col_q;
  assign commonControl = {tc_q, tr_q, kstep_q, nstep_q, div_q};

endmodule

// File: tb/tb_conv_unit_sequencer.sv
// Scoreboard bench for conv_unit_sequencer: per-cycle expected outputs derived from the job config.
module tb_conv_unit_sequencer;

  localparam int D  = 4;
  localparam int Cw = 20;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  cfgTr = '0, cfgTc = '0, cfgConvDivIni = '0;
  logic [6:0]  cfgKernelStep = '0, cfgNeuronStep = '0, cfgMacCycles = '0, cfgNumTiles = '0;
  logic [10:0] cfgKBase = '0, cfgNBase = '0;
  logic        busy, done, psumValid;
  logic [10:0] kBuffAddr, nBuffAddr;
  logic [3:0]  rowControl;
  logic [31:0] columnControl;
  logic [19:0] commonControl;

  conv_unit_sequencer #(.depth(2), .Al(7), .Ab(11)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .start         (start),
    .hold          (hold),
    .cfgTr         (cfgTr),
    .cfgTc         (cfgTc),
    .cfgKernelStep (cfgKernelStep),
    .cfgNeuronStep (cfgNeuronStep),
    .cfgConvDivIni (cfgConvDivIni),
    .cfgMacCycles  (cfgMacCycles),
    .cfgNumTiles   (cfgNumTiles),
    .cfgKBase      (cfgKBase),
    .cfgNBase      (cfgNBase),
    .busy          (busy),
    .done          (done),
    .psumValid     (psumValid),
    .kBuffAddr     (kBuffAddr),
    .nBuffAddr     (nBuffAddr),
    .rowControl    (rowControl),
    .columnControl (columnControl),
    .commonControl (commonControl)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  row;
    logic [3:0]  ctl;   // {shiftOut, clr, accEn, loadN}
    logic        psum, busy, done, ck, cn;
    logic [10:0] ka, na;
    logic [19:0] cc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] col_of(input logic [3:0] c);
    return {4{4'b0000, c}};
  endfunction

  function automatic exp_t mk(input logic [3:0] row, input logic [3:0] ctl, input logic psum,
                              input logic bsy, input logic dn, input logic ck, input int ka,
                              input logic cn, input int na, input logic [19:0] cc);
    exp_t e;
    e.row = row; e.ctl = ctl; e.psum = psum; e.busy = bsy; e.done = dn;
    e.ck = ck; e.ka = 11'(ka); e.cn = cn; e.na = 11'(na); e.cc = cc;
    return e;
  endfunction

  task automatic push_hold(input int hold_after, input int hold_len);
    exp_t e;
    if (sb.size() - 1 == hold_after) begin
      for (int h = 0; h < hold_len; h++) begin
        e = sb[$];
        e.row = '0; e.ctl = '0; e.psum = 1'b0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_job(input int kb, input int ks, input int nb, input int ns, input int m,
                          input int n, input int hold_after, input int hold_len,
                          input logic [19:0] cc);
    int me, ne;
    me = (m == 0) ? 1 : m;
    ne = (n == 0) ? 1 : n;
    for (int t = 0; t < ne; t++) begin
      for (int r = 0; r < D; r++) begin
        sb.push_back(mk(4'(1 << r), (r == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b1, 1'b0,
                        1'b1, kb + r * ks, 1'b0, 0, cc));
        push_hold(hold_after, hold_len);
      end
      for (int k = 0; k < me; k++) begin
        sb.push_back(mk(4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1,
                        (nb + t * ns + k) % 2048, cc));
        push_hold(hold_after, hold_len);
      end
      for (int r = 0; r < D; r++) begin
        sb.push_back(mk(4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, cc));
        push_hold(hold_after, hold_len);
      end
    end
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, cc));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, cc));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_row"}, 64'(rowControl), 64'd0);
    check_eq({tag, "_col"}, 64'(columnControl), 64'd0);
    check_eq({tag, "_psum"}, 64'(psumValid), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_kaddr"}, 64'(kBuffAddr), 64'd0);
    check_eq({tag, "_naddr"}, 64'(nBuffAddr), 64'd0);
    check_eq({tag, "_common"}, 64'(commonControl), 64'd0);
  endtask

  task automatic run_job(input int tr, input int tc, input int dv, input int kb, input int ks,
                         input int nb, input int ns, input int m, input int n,
                         input int hold_after, input int hold_len, input int start_at,
                         input int rst_at);
    logic [19:0] cc;
    exp_t e;
    int total, dones, busy_cycles, me, ne;
    bit aborted;
    cc = {2'(tc), 2'(tr), 7'(ks), 7'(ns), 2'(dv)};
    me = (m == 0) ? 1 : m;
    ne = (n == 0) ? 1 : n;
    sb.delete();
    push_job(kb, ks, nb, ns, m, n, hold_after, hold_len, cc);
    total = sb.size();
    dones = 0;
    busy_cycles = 0;
    aborted = 1'b0;
    @(negedge CLK);
    cfgTr = 2'(tr); cfgTc = 2'(tc); cfgConvDivIni = 2'(dv);
    cfgKBase = 11'(kb); cfgKernelStep = 7'(ks);
    cfgNBase = 11'(nb); cfgNeuronStep = 7'(ns);
    cfgMacCycles = 7'(m); cfgNumTiles = 7'(n);
    start = 1'b1;
    for (int i = 0; i < total; i++) begin
      @(negedge CLK);
      start = 1'b0;
      hold = 1'b0;
      e = sb.pop_front();
      check_eq("row", 64'(rowControl), 64'(e.row));
      check_eq("col", 64'(columnControl), 64'(col_of(e.ctl)));
      check_eq("psum", 64'(psumValid), 64'(e.psum));
      check_eq("busy", 64'(busy), 64'(e.busy));
      check_eq("done", 64'(done), 64'(e.done));
      check_eq("common", 64'(commonControl), 64'(e.cc));
      if (e.ck) check_eq("kaddr", 64'(kBuffAddr), 64'(e.ka));
      if (e.cn) check_eq("naddr", 64'(nBuffAddr), 64'(e.na));
      dones += int'(done);
      busy_cycles += int'(busy);
      if (i >= hold_after && i < hold_after + hold_len) hold = 1'b1;
      if (i == start_at) begin
        start = 1'b1;
        cfgTr = 2'd0; cfgTc = 2'd3; cfgConvDivIni = 2'd2;
        cfgKBase = 11'h555; cfgKernelStep = 7'd9;
        cfgNBase = 11'h2AA; cfgNeuronStep = 7'd33;
        cfgMacCycles = 7'd1; cfgNumTiles = 7'd5;
      end
      if (i == rst_at) begin
        #2 RSTn = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) begin
          @(negedge CLK);
          check_eq("rst_busy", 64'(busy), 64'd0);
          check_eq("rst_done", 64'(done), 64'd0);
        end
        RSTn = 1'b1;
        @(negedge CLK);
        check_eq("post_rst_done", 64'(done), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check_eq("done_pulses", 64'(dones), 64'd1);
      check_eq("busy_cycles", 64'(busy_cycles), 64'(ne * (2 * D + me) + 1 + hold_len));
    end
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("idle_busy", 64'(busy), 64'd0);

    // tr tc dv  kb    ks nb     ns m  n  hold_after len start_at rst_at
    run_job(1, 2, 3, 'h10,  4, 'h20,  5, 9, 1, -1, 0, -1, -1);
    run_job(3, 0, 1, 'h100, 1, 0,     8, 2, 3, -1, 0, -1, -1);
    run_job(1, 2, 3, 'h10,  4, 'h20,  5, 9, 1, 6,  3, -1, -1);
    run_job(2, 1, 0, 'h40,  3, 'h33,  2, 0, 0, -1, 0, -1, -1);
    run_job(0, 3, 2, 'h7F0, 7, 'h7FF, 1, 2, 2, -1, 0, -1, -1);
    run_job(1, 2, 3, 'h10,  4, 'h20,  5, 9, 1, -1, 0, 8,  -1);
    run_job(2, 2, 1, 'h08,  2, 'h10,  3, 3, 2, -1, 0, -1, 8);
    run_job(3, 1, 2, 'h18,  6, 'h44,  9, 1, 1, -1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
